// File: rtl/cpu_sequencer_if.sv
// Bus bundle between the sequencer and its surroundings:
// instruction/data memory handshakes, ALU controls and status.
interface cpu_sequencer_if;
  logic [15:0] i_imem_data;
  logic        i_imem_ready;
  logic [7:0]  i_dmem_rdata;
  logic        i_dmem_ready;
  logic [7:0]  i_alu_result;
  logic        i_alu_flag;
  logic        i_alu_mem_write;
  logic        i_alu_mem_read;
  logic        i_alu_reg_write;
  logic        i_alu_hlt;
  logic        i_alu_branch_taken;
  logic        i_alu_jmp;
  logic        o_imem_req;
  logic [7:0]  o_imem_addr;
  logic [15:0] o_ir;
  logic        o_dmem_req;
  logic        o_dmem_we;
  logic [7:0]  o_dmem_addr;
  logic        o_rf_we;
  logic [1:0]  o_rf_waddr;
  logic [7:0]  o_rf_wdata;
  logic        o_flag;
  logic [2:0]  o_state;
  logic        o_halted;
  logic [15:0] o_retired;

  modport master (
    input  i_imem_data, i_imem_ready,
    input  i_dmem_rdata, i_dmem_ready,
    input  i_alu_result, i_alu_flag,
    input  i_alu_mem_write, i_alu_mem_read,
    input  i_alu_reg_write, i_alu_hlt,
    input  i_alu_branch_taken, i_alu_jmp,
    output o_imem_req, o_imem_addr, o_ir,
    output o_dmem_req, o_dmem_we, o_dmem_addr,
    output o_rf_we, o_rf_waddr, o_rf_wdata,
    output o_flag, o_state, o_halted, o_retired
  );

  modport slave (
    output i_imem_data, i_imem_ready,
    output i_dmem_rdata, i_dmem_ready,
    output i_alu_result, i_alu_flag,
    output i_alu_mem_write, i_alu_mem_read,
    output i_alu_reg_write, i_alu_hlt,
    output i_alu_branch_taken, i_alu_jmp,
    input  o_imem_req, o_imem_addr, o_ir,
    input  o_dmem_req, o_dmem_we, o_dmem_addr,
    input  o_rf_we, o_rf_waddr, o_rf_wdata,
    input  o_flag, o_state, o_halted, o_retired
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: owns pc/ir and steps each
// instruction through fetch, decode, execute, mem, writeback.
module cpu_sequencer (
  input logic             i_clk,
  input logic             i_rst,
  cpu_sequencer_if.master bus
);

  localparam logic [2:0] S_FETCH     = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_EXECUTE   = 3'd2;
  localparam logic [2:0] S_MEM       = 3'd3;
  localparam logic [2:0] S_WRITEBACK = 3'd4;
  localparam logic [2:0] S_HALT      = 3'd5;

  logic [2:0]  state_q;
  logic [2:0]  state_d;
  logic [7:0]  pc_q;
  logic [7:0]  pc_d;
  logic [15:0] ir_q;
  logic [7:0]  alu_q;
  logic [7:0]  mdr_q;
  logic        is_load_q;
  logic        is_store_q;
  logic        flag_q;
  logic [15:0] retired;
  logic        retire;
  logic        flag_op;

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    pc_d    = pc_q;
    case (state_q)
      S_FETCH:
        state_d = bus.i_imem_ready ? S_DECODE : S_FETCH;
      S_DECODE:
        state_d = S_EXECUTE;
      S_EXECUTE: begin
        if (bus.i_alu_hlt) begin
          state_d = S_HALT;
        end else if (bus.i_alu_jmp) begin
          pc_d    = bus.i_alu_result;
          state_d = S_FETCH;
        end else if (bus.i_alu_branch_taken) begin
          pc_d    = bus.i_alu_result;
          state_d = S_FETCH;
        end else if (bus.i_alu_mem_read
                     || bus.i_alu_mem_write) begin
          state_d = S_MEM;
        end else if (bus.i_alu_reg_write) begin
          state_d = S_WRITEBACK;
        end else begin
          pc_d    = pc_q + 8'd1;
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        if (!bus.i_dmem_ready) begin
          state_d = S_MEM;
        end else if (is_store_q) begin
          pc_d    = pc_q + 8'd1;
          state_d = S_FETCH;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        pc_d    = pc_q + 8'd1;
        state_d = S_FETCH;
      end
      S_HALT:
        state_d = S_HALT;
      default:
        state_d = S_FETCH;
    endcase
  end

  // An instruction retires when it leaves the pipeline for good.
  assign retire =
    (state_d == S_FETCH && (state_q == S_EXECUTE
      || state_q == S_MEM || state_q == S_WRITEBACK))
    || (state_d == S_HALT && state_q == S_EXECUTE);

  assign flag_op = (ir_q[15:12] == 4'b0001)
                || (ir_q[15:12] == 4'b0010);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q       <= 8'h00;
      ir_q       <= 16'h0000;
      alu_q      <= 8'h00;
      mdr_q      <= 8'h00;
      is_load_q  <= 1'b0;
      is_store_q <= 1'b0;
      flag_q     <= 1'b0;
      retired    <= 16'h0000;
    end else begin
      pc_q <= pc_d;
      if (state_q == S_FETCH && bus.i_imem_ready)
        ir_q <= bus.i_imem_data;
      if (state_q == S_EXECUTE) begin
        alu_q      <= bus.i_alu_result;
        is_load_q  <= bus.i_alu_mem_read;
        is_store_q <= bus.i_alu_mem_write;
        if (flag_op) flag_q <= bus.i_alu_flag;
      end
      if (state_q == S_MEM && bus.i_dmem_ready)
        mdr_q <= bus.i_dmem_rdata;
      if (retire) retired <= retired + 16'd1;
    end
  end

  always_comb begin
    bus.o_imem_req = (state_q == S_FETCH);
    bus.o_dmem_req = (state_q == S_MEM);
    bus.o_rf_we    = (state_q == S_WRITEBACK);
    bus.o_halted   = (state_q == S_HALT);
  end

  assign bus.o_imem_addr = pc_q;
  assign bus.o_ir        = ir_q;
  assign bus.o_dmem_we   = is_store_q;
  assign bus.o_dmem_addr = alu_q;
  assign bus.o_rf_waddr  = ir_q[11:10];
  assign bus.o_rf_wdata  = is_load_q ? mdr_q : alu_q;
  assign bus.o_flag      = flag_q;
  assign bus.o_state     = state_q;
  assign bus.o_retired   = retired;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: small ALU/memory model plus
// scoreboard queues for register writes and data accesses.
module tb_cpu_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cpu_sequencer_if bus ();

  cpu_sequencer dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.master)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [15:0] imem [256];
  logic [7:0]  rf [4];
  logic        imem_rdy = 1'b0;
  logic        dforce = 1'b0;
  logic [7:0]  rdata = 8'h00;
  int          dlat = 0;
  int          dcnt = 0;

  assign bus.i_imem_data  = imem[bus.o_imem_addr];
  assign bus.i_imem_ready = imem_rdy;
  assign bus.i_dmem_rdata = rdata;
  assign bus.i_dmem_ready =
    dforce | (bus.o_dmem_req && dcnt >= dlat);

  always @(posedge clk) begin
    if (bus.o_dmem_req && !bus.i_dmem_ready) dcnt <= dcnt + 1;
    else dcnt <= 0;
  end

  // Reference ALU: opcodes 0 NOP,1 ADD,2 SUB,3 LDI,4 LDM,
  // 5 ST,6 BEQ,7 JMP,8 HLT.
  logic [8:0] sum9;
  always_comb begin
    sum9 = 9'd0;
    bus.i_alu_result = 8'h00;
    bus.i_alu_flag = 1'b0;
    bus.i_alu_mem_write = 1'b0;
    bus.i_alu_mem_read = 1'b0;
    bus.i_alu_reg_write = 1'b0;
    bus.i_alu_hlt = 1'b0;
    bus.i_alu_branch_taken = 1'b0;
    bus.i_alu_jmp = 1'b0;
    case (bus.o_ir[15:12])
      4'h1: begin
        sum9 = {1'b0, rf[bus.o_ir[11:10]]}
             + {1'b0, rf[bus.o_ir[9:8]]};
        bus.i_alu_result = sum9[7:0];
        bus.i_alu_flag = sum9[8];
        bus.i_alu_reg_write = 1'b1;
      end
      4'h2: begin
        bus.i_alu_result = rf[bus.o_ir[11:10]] - rf[bus.o_ir[9:8]];
        bus.i_alu_flag = rf[bus.o_ir[11:10]] >= rf[bus.o_ir[9:8]];
        bus.i_alu_reg_write = 1'b1;
      end
      4'h3: begin
        bus.i_alu_result = {4'h0, bus.o_ir[3:0]};
        bus.i_alu_reg_write = 1'b1;
      end
      4'h4: begin
        bus.i_alu_result = {4'h0, bus.o_ir[3:0]};
        bus.i_alu_mem_read = 1'b1;
        bus.i_alu_reg_write = 1'b1;
      end
      4'h5: begin
        bus.i_alu_result = {4'h0, bus.o_ir[3:0]};
        bus.i_alu_mem_write = 1'b1;
      end
      4'h6: begin
        bus.i_alu_result = bus.o_ir[7:0];
        bus.i_alu_branch_taken =
          rf[bus.o_ir[11:10]] == rf[bus.o_ir[9:8]];
      end
      4'h7: begin
        bus.i_alu_result = bus.o_ir[7:0];
        bus.i_alu_jmp = 1'b1;
      end
      4'h8: bus.i_alu_hlt = 1'b1;
      default: ;
    endcase
  end

  typedef struct packed {
    logic [1:0] a;
    logic [7:0] d;
  } rf_exp_t;

  typedef struct packed {
    logic       we;
    logic [7:0] a;
  } dm_exp_t;

  rf_exp_t rf_q[$];
  dm_exp_t dm_q[$];
  rf_exp_t rf_e;
  dm_exp_t dm_e;
  dm_exp_t dm_held;
  logic    req_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.o_rf_we) begin
      total_cnt++;
      if (rf_q.size() == 0) begin
        $display("FAIL rf_write unexpected waddr=%0d wdata=%h",
                 bus.o_rf_waddr, bus.o_rf_wdata);
      end else begin
        rf_e = rf_q.pop_front();
        if (bus.o_rf_waddr !== rf_e.a || bus.o_rf_wdata !== rf_e.d)
          $display("FAIL rf_write got %0d/%h want %0d/%h",
                   bus.o_rf_waddr, bus.o_rf_wdata, rf_e.a, rf_e.d);
        else pass_cnt++;
      end
    end
    if (bus.o_dmem_req && !req_prev) begin
      total_cnt++;
      dm_held = '{bus.o_dmem_we, bus.o_dmem_addr};
      if (dm_q.size() == 0) begin
        $display("FAIL dmem_req unexpected we=%b addr=%h",
                 bus.o_dmem_we, bus.o_dmem_addr);
      end else begin
        dm_e = dm_q.pop_front();
        if (dm_held !== dm_e)
          $display("FAIL dmem_req got we=%b addr=%h want we=%b addr=%h",
                   dm_held.we, dm_held.a, dm_e.we, dm_e.a);
        else pass_cnt++;
      end
    end else if (bus.o_dmem_req) begin
      total_cnt++;
      if (bus.o_dmem_we !== dm_held.we || bus.o_dmem_addr !== dm_held.a)
        $display("FAIL dmem_stable got we=%b addr=%h want we=%b addr=%h",
                 bus.o_dmem_we, bus.o_dmem_addr, dm_held.we, dm_held.a);
      else pass_cnt++;
    end
    req_prev = bus.o_dmem_req;
  end

  task automatic apply_reset;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_one(output int cyc, output int reqs,
                         output int stores);
    cyc = 0;
    reqs = 0;
    stores = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (bus.o_dmem_req) reqs++;
      if (bus.o_dmem_req && bus.o_dmem_we) stores++;
    end while (bus.o_state != 3'd0 && cyc < 60);
    if (cyc >= 60) cyc = -1;
  endtask

  task automatic test_reset;
    imem_rdy = 1'b0;
    apply_reset();
    total_cnt++;
    if (bus.o_state !== 3'd0 || bus.o_imem_req !== 1'b1
        || bus.o_imem_addr !== 8'h00)
      $display("FAIL reset_fetch state=%0d req=%b addr=%h want 0/1/00",
               bus.o_state, bus.o_imem_req, bus.o_imem_addr);
    else pass_cnt++;
    total_cnt++;
    if (bus.o_dmem_req !== 1'b0 || bus.o_rf_we !== 1'b0
        || bus.o_halted !== 1'b0)
      $display("FAIL reset_strobes dreq=%b rfwe=%b halt=%b want 0/0/0",
               bus.o_dmem_req, bus.o_rf_we, bus.o_halted);
    else pass_cnt++;
    total_cnt++;
    if (bus.o_retired !== 16'h0000 || bus.o_flag !== 1'b0
        || bus.o_ir !== 16'h0000)
      $display("FAIL reset_regs ret=%h flag=%b ir=%h want 0000/0/0000",
               bus.o_retired, bus.o_flag, bus.o_ir);
    else pass_cnt++;
  endtask

  task automatic test_add;
    imem[0] = 16'h1400;
    rf[0] = 8'hF0;
    rf[1] = 8'h20;
    rf_q.push_back('{2'd1, 8'h10});
    imem_rdy = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (bus.o_rf_we !== 1'b1 || bus.o_state !== 3'd4)
      $display("FAIL add_wb_cycle4 rfwe=%b state=%0d want 1/4",
               bus.o_rf_we, bus.o_state);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (bus.o_state !== 3'd0 || bus.o_imem_addr !== 8'h01)
      $display("FAIL add_next state=%0d pc=%h want 0/01",
               bus.o_state, bus.o_imem_addr);
    else pass_cnt++;
    total_cnt++;
    if (bus.o_flag !== 1'b1 || bus.o_retired !== 16'd1)
      $display("FAIL add_flag_ret flag=%b ret=%0d want 1/1",
               bus.o_flag, bus.o_retired);
    else pass_cnt++;
  endtask

  task automatic test_ldm_wait;
    int cyc, reqs, st;
    imem[1] = 16'h4808;
    dlat = 3;
    rdata = 8'hA5;
    dm_q.push_back('{1'b0, 8'h08});
    rf_q.push_back('{2'd2, 8'hA5});
    run_one(cyc, reqs, st);
    total_cnt++;
    if (cyc !== 8 || reqs !== 4 || st !== 0)
      $display("FAIL ldm_timing cyc=%0d reqs=%0d st=%0d want 8/4/0",
               cyc, reqs, st);
    else pass_cnt++;
    total_cnt++;
    if (bus.o_imem_addr !== 8'h02 || bus.o_flag !== 1'b1
        || bus.o_retired !== 16'd2)
      $display("FAIL ldm_after pc=%h flag=%b ret=%0d want 02/1/2",
               bus.o_imem_addr, bus.o_flag, bus.o_retired);
    else pass_cnt++;
    dlat = 0;
  endtask

  task automatic test_st_branch_jmp;
    int cyc, reqs, st, stores;
    int exp_cyc [4] = '{4, 3, 3, 3};
    logic [7:0] exp_pc [4] = '{8'h01, 8'h40, 8'hFF, 8'h00};
    imem[0] = 16'h5003;
    imem[1] = 16'h6040;
    imem[8'h40] = 16'h70FF;
    imem[8'hFF] = 16'h0000;
    rf[0] = 8'h11;
    imem_rdy = 1'b1;
    dm_q.push_back('{1'b1, 8'h03});
    apply_reset();
    stores = 0;
    for (int i = 0; i < 4; i++) begin
      run_one(cyc, reqs, st);
      stores += st;
      total_cnt++;
      if (cyc !== exp_cyc[i] || bus.o_imem_addr !== exp_pc[i])
        $display("FAIL seq_%0d cyc=%0d pc=%h want %0d/%h",
                 i, cyc, bus.o_imem_addr, exp_cyc[i], exp_pc[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (stores !== 1 || bus.o_retired !== 16'd4)
      $display("FAIL seq_totals stores=%0d ret=%0d want 1/4",
               stores, bus.o_retired);
    else pass_cnt++;
  endtask

  task automatic test_halt;
    int cyc, reqs, st, bad;
    imem[0] = 16'h7005;
    imem[5] = 16'h8000;
    imem_rdy = 1'b1;
    apply_reset();
    run_one(cyc, reqs, st);
    repeat (3) @(negedge clk);
    total_cnt++;
    if (bus.o_halted !== 1'b1 || bus.o_state !== 3'd5
        || bus.o_imem_addr !== 8'h05)
      $display("FAIL halt_entry halt=%b state=%0d pc=%h want 1/5/05",
               bus.o_halted, bus.o_state, bus.o_imem_addr);
    else pass_cnt++;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.o_imem_req || bus.o_dmem_req || bus.o_rf_we
          || !bus.o_halted || bus.o_imem_addr != 8'h05) bad++;
    end
    total_cnt++;
    if (bad !== 0 || bus.o_retired !== 16'd2)
      $display("FAIL halt_hold bad=%0d ret=%0d want 0/2",
               bad, bus.o_retired);
    else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total_cnt++;
    if (bus.o_state !== 3'd0 || bus.o_imem_addr !== 8'h00)
      $display("FAIL halt_reset state=%0d pc=%h want 0/00",
               bus.o_state, bus.o_imem_addr);
    else pass_cnt++;
  endtask

  task automatic test_rst_mem;
    int cyc, reqs, st, bad, n;
    imem[0] = 16'h0000;
    imem[1] = 16'h4808;
    imem_rdy = 1'b1;
    dlat = 1000;
    apply_reset();
    run_one(cyc, reqs, st);
    dm_q.push_back('{1'b0, 8'h08});
    n = 0;
    while (!bus.o_dmem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    total_cnt++;
    if (bus.o_dmem_req !== 1'b1 || bus.o_retired !== 16'd1)
      $display("FAIL rstmem_enter dreq=%b ret=%0d want 1/1",
               bus.o_dmem_req, bus.o_retired);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    imem_rdy = 1'b0;
    total_cnt++;
    if (bus.o_dmem_req !== 1'b0 || bus.o_imem_req !== 1'b1
        || bus.o_retired !== 16'd0)
      $display("FAIL rstmem_drop dreq=%b ireq=%b ret=%0d want 0/1/0",
               bus.o_dmem_req, bus.o_imem_req, bus.o_retired);
    else pass_cnt++;
    dforce = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.o_dmem_req || bus.o_rf_we || bus.o_state != 3'd0
          || bus.o_imem_addr != 8'h00) bad++;
    end
    total_cnt++;
    if (bad !== 0)
      $display("FAIL rstmem_late_ready bad=%0d want 0", bad);
    else pass_cnt++;
    dforce = 1'b0;
    dlat = 0;
  endtask

  task automatic test_retire_wrap;
    imem[0] = 16'h0000;
    imem_rdy = 1'b1;
    apply_reset();
    force dut.retired = 16'hFFFF;
    @(negedge clk);
    release dut.retired;
    @(negedge clk);
    total_cnt++;
    if (bus.o_retired !== 16'hFFFF)
      $display("FAIL wrap_preset ret=%h want ffff", bus.o_retired);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (bus.o_retired !== 16'h0000 || bus.o_imem_addr !== 8'h01)
      $display("FAIL wrap_ret ret=%h pc=%h want 0000/01",
               bus.o_retired, bus.o_imem_addr);
    else pass_cnt++;
  endtask

  task automatic test_drain;
    total_cnt++;
    if (rf_q.size() !== 0 || dm_q.size() !== 0)
      $display("FAIL scoreboard_drain rf=%0d dm=%0d want 0/0",
               rf_q.size(), dm_q.size());
    else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
    for (int i = 0; i < 4; i++) rf[i] = 8'h00;
    test_reset();
    test_add();
    test_ldm_wait();
    test_st_branch_jmp();
    test_halt();
    test_rst_mem();
    test_retire_wrap();
    test_drain();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control sequencer for the 8-bit processor core. It owns the program counter and instruction register, drives the instruction-memory and data-memory request handshakes, and steps each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK. It consumes the ALU's combinational control outputs, which are evaluated on the held instruction, and turns them into register-file and memory strobes, PC updates and halt.

## Interface
- No parameters. All widths are fixed: PC 8 bits, instruction 16 bits, data 8 bits.
- i_clk  in  1  single clock; all state updates on the rising edge
- i_rst  in  1  synchronous, active-high reset
- i_imem_data  in  16  instruction word returned for o_imem_addr
- i_imem_ready  in  1  instruction fetch complete this cycle
- i_dmem_rdata  in  8  load data
- i_dmem_ready  in  1  data access complete this cycle
- i_alu_result  in  8  ALU result (data, memory address or branch/jump target)
- i_alu_flag, i_alu_mem_write, i_alu_mem_read, i_alu_reg_write, i_alu_hlt, i_alu_branch_taken, i_alu_jmp  in  1 each  ALU control outputs
- o_imem_req  out  1  fetch request
- o_imem_addr  out  8  equals PC
- o_ir  out  16  instruction register, split into these fields:
  - [15:12] opcode
  - [11:10] reg0 (destination)
  - [9:8] reg1
  - [7:6] reg2
  - [5:4] ignored
  - [3:0] reserved/immediate
- o_dmem_req  out  1  data access request
- o_dmem_we  out  1  1 = store, 0 = load; valid while o_dmem_req
- o_dmem_addr  out  8  latched ALU result
- o_rf_we  out  1  register-file write strobe
- o_rf_waddr  out  2  o_ir[11:10]
- o_rf_wdata  out  8  load data for LDM, otherwise latched ALU result
- o_flag  out  1  carry/no-borrow flag, registered
- o_state  out  3  current state encoding
- o_halted  out  1  core halted
- o_retired  out  16  retired-instruction count

## Operation
- State encoding:
  - FETCH = 0
  - DECODE = 1
  - EXECUTE = 2
  - MEM = 3
  - WRITEBACK = 4
  - HALT = 5
  - Codes 6 and 7 go to FETCH on the next edge.
- Strobes are Moore outputs, decoded from the state register only:
  - o_imem_req = FETCH
  - o_dmem_req = MEM
  - o_rf_we = WRITEBACK
  - o_halted = HALT
- FETCH:
  - Hold o_imem_req until i_imem_ready.
  - On ready, load ir from i_imem_data and go to DECODE.
- DECODE: one cycle so register-file reads and the ALU settle on the new ir. Always goes to EXECUTE.
- EXECUTE (one cycle):
  - Latch alu_q from i_alu_result and the load/store kind from the ALU read/write flags.
  - o_flag is updated from i_alu_flag only when opcode is ADD (0001) or SUB (0010); otherwise it holds.
  - Next state, first matching condition wins:
    - i_alu_hlt: go to HALT.
    - i_alu_jmp: pc = i_alu_result, go to FETCH.
    - i_alu_branch_taken: pc = i_alu_result, go to FETCH.
    - i_alu_mem_read or i_alu_mem_write: go to MEM.
    - i_alu_reg_write: go to WRITEBACK.
    - Otherwise (NOP, untaken BEQ/BENQ): pc = pc+1, go to FETCH.
- MEM:
  - Hold o_dmem_req, with o_dmem_we = latched store kind and o_dmem_addr = alu_q, until i_dmem_ready.
  - Store completes: pc+1, go to FETCH.
  - Load completes: mdr = i_dmem_rdata, go to WRITEBACK.
- WRITEBACK:
  - o_rf_we is high for exactly one cycle.
  - Writes mdr after a load, otherwise alu_q.
  - Then pc+1, go to FETCH.
- HALT: absorbing state; only i_rst leaves it. No requests or strobes are driven.
- o_retired increments by 1 on every transition into FETCH from EXECUTE, MEM or WRITEBACK, and on entry to HALT.
- Arithmetic wraps modulo width: pc 0xFF+1 gives 0x00; o_retired 0xFFFF+1 gives 0x0000.

## Timing
- Reset values: state FETCH, pc 0x00, ir 0x0000, alu_q 0, mdr 0, o_flag 0, o_retired 0.
  - Resulting outputs: o_imem_req 1, o_imem_addr 0x00, all other strobes 0, o_halted 0.
- Reset is honoured in any state, including mid-MEM or mid-FETCH wait. The outstanding request drops on the next edge; it is not completed or replayed.
- Cycles per instruction with ready asserted in the same cycle as the request:
  - NOP, JMP, branch: 3
  - ST: 4
  - ALU ops and LDI: 4
  - LDM: 5
  - HLT: 3 to HALT
- Each memory wait cycle adds 1 cycle.
- A ready input seen while the matching req is low is ignored.
- Address and data outputs are stable for the whole time the request is held.
- A taken branch or jump to the current pc is legal and loops.

## Test plan
- Reset, then fetch `ADD r1` (0x1400) with r0=0xF0, r1=0x20 and zero-wait memory:
  - o_rf_we pulses in cycle 4 with waddr 1 and wdata 0x10.
  - o_flag = 1; pc = 0x01; o_retired = 1.
- LDM with i_dmem_ready delayed 3 cycles and rdata 0xA5:
  - o_dmem_req is held 4 cycles with we = 0.
  - WRITEBACK writes 0xA5.
  - Instruction totals 8 cycles.
- ST, then BEQ taken to 0x40, then JMP to 0xFF, then NOP:
  - One store pulse with we = 1.
  - pc sequence 0x01, 0x40, 0xFF, 0x00 (wrap).
- HLT at pc 0x05:
  - o_halted = 1 from cycle 3 on; pc stays 0x05; no further requests for 20 cycles.
  - Asserting i_rst gives state FETCH and pc 0x00 on the next edge.
- Assert i_rst during a MEM wait with o_dmem_req high:
  - Next cycle o_dmem_req = 0, o_imem_req = 1, o_retired = 0.
  - A late i_dmem_ready has no effect.
- Force o_retired to 0xFFFF and retire one NOP: the counter reads 0x0000.
